// File: rtl/ws2812b_word_assembler.sv
// Packs decoded WS2812B bits into WORD_BITS-wide words and queues them in a
// show-ahead FIFO with valid/ready output, overflow flag and per-frame word count.
module ws2812b_word_assembler #(
    parameter int unsigned WORD_BITS  = 24,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            bit_valid,
    input  logic                            bit_value,
    input  logic                            frame_reset,
    input  logic                            word_ready,
    output logic                            word_valid,
    output logic [WORD_BITS-1:0]            word_data,
    output logic [$clog2(WORD_BITS)-1:0]    bit_count,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    input  logic                            overflow_clr,
    output logic [15:0]                     frame_words
);

    localparam int unsigned CNT_W = $clog2(WORD_BITS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WORD_BITS-1:0] shift_q;
    logic [WORD_BITS-1:0] shift_next;
    logic [WORD_BITS-1:0] head_next;
    logic [WORD_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_next;
    logic [LVL_W-1:0]     level_after_pop;
    logic [LVL_W-1:0]     level_next;
    logic                 accept;
    logic                 last_bit;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 push_ok;
    logic                 drop;

    // Datapath and FIFO bookkeeping for the current cycle.
    always_comb begin
        shift_next      = '0;
        if (MSB_FIRST) begin
            shift_next = {shift_q[WORD_BITS-2:0], bit_value};
        end else begin
            shift_next = {bit_value, shift_q[WORD_BITS-1:1]};
        end
        accept          = bit_valid && !frame_reset;
        last_bit        = (bit_count == CNT_W'(WORD_BITS - 1));
        push            = accept && last_bit;
        pop             = word_valid && word_ready;
        full            = (fifo_level == LVL_W'(FIFO_DEPTH));
        push_ok         = push && (!full || pop);
        drop            = push && full && !pop;
        level_after_pop = fifo_level - LVL_W'(pop);
        level_next      = level_after_pop + LVL_W'(push_ok);
        rd_next         = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        // When the FIFO drains to the incoming word, the new head is that word.
        head_next       = (level_after_pop == '0) ? shift_next : mem[rd_next];
    end

    // Bit accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_count <= '0;
        end else if (frame_reset) begin
            shift_q   <= '0;
            bit_count <= '0;
        end else if (bit_valid) begin
            if (last_bit) begin
                shift_q   <= '0;
                bit_count <= '0;
            end else begin
                shift_q   <= shift_next;
                bit_count <= bit_count + CNT_W'(1);
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (push_ok) begin
            mem[wr_ptr] <= shift_next;
            wr_ptr      <= wr_ptr + PTR_W'(1);
        end
    end

    // Read side, registered head word and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            fifo_level  <= '0;
            word_valid  <= 1'b0;
            word_data   <= '0;
            overflow    <= 1'b0;
            frame_words <= '0;
        end else begin
            rd_ptr     <= rd_next;
            fifo_level <= level_next;
            word_valid <= (level_next != '0);
            if (level_next != '0) begin
                word_data <= head_next;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
            if (frame_reset) begin
                frame_words <= '0;
            end else if (push_ok && (frame_words != 16'hFFFF)) begin
                frame_words <= frame_words + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812b_word_assembler.sv
// Self-checking bench: queue-based reference model compared every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_ws2812b_word_assembler;

    logic        clk;
    logic        rst_n;
    logic        bit_valid;
    logic        bit_value;
    logic        frame_reset;
    logic        word_ready;
    logic        overflow_clr;
    logic        word_valid;
    logic [23:0] word_data;
    logic [4:0]  bit_count;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [15:0] frame_words;

    logic        b8_valid;
    logic        b8_value;
    logic        a_valid, b_valid, a_ovf, b_ovf;
    logic [7:0]  a_data, b_data;
    logic [2:0]  a_cnt, b_cnt, a_lvl, b_lvl;
    logic [15:0] a_fw, b_fw;

    int checks = 0;
    int errors = 0;

    ws2812b_word_assembler dut (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_value(bit_value),
        .frame_reset(frame_reset), .word_ready(word_ready), .word_valid(word_valid),
        .word_data(word_data), .bit_count(bit_count), .fifo_level(fifo_level),
        .overflow(overflow), .overflow_clr(overflow_clr), .frame_words(frame_words)
    );

    ws2812b_word_assembler #(.WORD_BITS(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .bit_valid(b8_valid), .bit_value(b8_value),
        .frame_reset(1'b0), .word_ready(1'b1), .word_valid(a_valid),
        .word_data(a_data), .bit_count(a_cnt), .fifo_level(a_lvl),
        .overflow(a_ovf), .overflow_clr(1'b0), .frame_words(a_fw)
    );

    ws2812b_word_assembler #(.WORD_BITS(8), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .bit_valid(b8_valid), .bit_value(b8_value),
        .frame_reset(1'b0), .word_ready(1'b1), .word_valid(b_valid),
        .word_data(b_data), .bit_count(b_cnt), .fifo_level(b_lvl),
        .overflow(b_ovf), .overflow_clr(1'b0), .frame_words(b_fw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue, a bit accumulator and counters.
    logic [23:0] q[$];
    logic [31:0] acc;
    int          nbits;
    int          fw;
    logic        m_ovf;
    logic [23:0] m_last;
    logic        m_done;
    logic [23:0] m_word;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            acc = 0; nbits = 0; fw = 0; m_ovf = 1'b0; m_last = '0;
        end else begin
            m_done = 1'b0;
            if (frame_reset) begin
                acc = 0; nbits = 0; fw = 0;
            end else if (bit_valid) begin
                acc = {acc[30:0], bit_value};
                nbits++;
                if (nbits == 24) begin
                    m_done = 1'b1; m_word = acc[23:0]; acc = 0; nbits = 0;
                end
            end
            if (q.size() != 0 && word_ready) m_last = q.pop_front();
            if (overflow_clr) m_ovf = 1'b0;
            if (m_done) begin
                if (q.size() < 4) begin
                    q.push_back(m_word);
                    if (fw < 65535) fw++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        #2;
        chk("model_valid", 32'(word_valid), 32'(q.size() != 0));
        chk("model_data", 32'(word_data), 32'((q.size() != 0) ? q[0] : m_last));
        chk("model_level", 32'(fifo_level), 32'(q.size()));
        chk("model_bitcnt", 32'(bit_count), 32'(nbits));
        chk("model_ovf", 32'(overflow), 32'(m_ovf));
        chk("model_fw", 32'(frame_words), 32'(fw));
    end

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_value = b;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic pop_one();
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(word_valid), 32'd0);
        chk({tag, "_data"}, 32'(word_data), 32'd0);
        chk({tag, "_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_bitcnt"}, 32'(bit_count), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_fw"}, 32'(frame_words), 32'd0);
    endtask

    logic [23:0] w6;
    logic [23:0] exp_pop[4];

    initial begin
        rst_n = 1'b0; bit_valid = 1'b0; bit_value = 1'b0; frame_reset = 1'b0;
        word_ready = 1'b0; overflow_clr = 1'b0; b8_valid = 1'b0; b8_value = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Default MSB-first pixel word with the consumer ready.
        word_ready = 1'b1;
        send_word(24'hA5C3F0);
        chk("t1_valid", 32'(word_valid), 32'd1);
        chk("t1_data", 32'(word_data), 32'hA5C3F0);
        chk("t1_fw", 32'(frame_words), 32'd1);
        chk("t1_bitcnt", 32'(bit_count), 32'd0);
        repeat (2) @(negedge clk);
        chk("t1_drained", 32'(word_valid), 32'd0);
        chk("t1_hold_last", 32'(word_data), 32'hA5C3F0);
        word_ready = 1'b0;

        // Bit order on 8-bit instances.
        for (int i = 0; i < 8; i++) begin
            b8_valid = 1'b1;
            b8_value = (i == 0);
            @(negedge clk);
        end
        b8_valid = 1'b0;
        chk("lsb_first_valid", 32'(a_valid), 32'd1);
        chk("lsb_first_data", 32'(a_data), 32'h01);
        chk("msb_first_data", 32'(b_data), 32'h80);

        // Overflow with the consumer stalled.
        frame_reset = 1'b1;
        @(negedge clk);
        frame_reset = 1'b0;
        chk("fr_fw_clear", 32'(frame_words), 32'd0);
        for (int k = 1; k <= 5; k++) send_word(24'(k));
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_fw", 32'(frame_words), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_pop_order", 32'(word_data), 32'(k));
            pop_one();
        end
        chk("ovf_empty", 32'(fifo_level), 32'd0);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Push into a full FIFO in the same cycle as a pop.
        for (int k = 1; k <= 4; k++) send_word(24'(k));
        chk("full_level", 32'(fifo_level), 32'd4);
        w6 = 24'h000006;
        for (int i = 23; i >= 1; i--) send_bit(w6[i]);
        word_ready = 1'b1;
        send_bit(w6[0]);
        word_ready = 1'b0;
        chk("pp_no_ovf", 32'(overflow), 32'd0);
        chk("pp_level", 32'(fifo_level), 32'd4);
        chk("pp_fw", 32'(frame_words), 32'd9);
        exp_pop[0] = 24'd2; exp_pop[1] = 24'd3; exp_pop[2] = 24'd4; exp_pop[3] = 24'd6;
        for (int k = 0; k < 4; k++) begin
            chk("pp_pop_order", 32'(word_data), 32'(exp_pop[k]));
            pop_one();
        end

        // frame_reset coincident with a bit discards it and realigns.
        send_word(24'h123456);
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        chk("fr_bitcnt_10", 32'(bit_count), 32'd10);
        frame_reset = 1'b1;
        bit_valid = 1'b1;
        bit_value = 1'b1;
        @(negedge clk);
        frame_reset = 1'b0;
        bit_valid = 1'b0;
        chk("fr_bitcnt_0", 32'(bit_count), 32'd0);
        chk("fr_keep_fifo", 32'(fifo_level), 32'd1);
        chk("fr_fw_zero", 32'(frame_words), 32'd0);
        send_word(24'hABCDEF);
        chk("fr_level2", 32'(fifo_level), 32'd2);
        chk("fr_fw_one", 32'(frame_words), 32'd1);
        chk("fr_pop_old", 32'(word_data), 32'h123456);
        pop_one();
        chk("fr_pop_new", 32'(word_data), 32'hABCDEF);
        pop_one();

        // Asynchronous reset mid-word with two words queued.
        send_word(24'h111111);
        send_word(24'h222222);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        chk("ar_level", 32'(fifo_level), 32'd2);
        chk("ar_bitcnt", 32'(bit_count), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(24'h5A5A5A);
        chk("ar_new_valid", 32'(word_valid), 32'd1);
        chk("ar_new_data", 32'(word_data), 32'h5A5A5A);
        chk("ar_new_fw", 32'(frame_words), 32'd1);
        pop_one();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812b_word_assembler.md
Name: ws2812b_word_assembler

Overview:
Parametrised successor to the 8-bit byte assembler in the WS2812B receive path. Collects decoded bits into words of WORD_BITS (default 24 = one GRB pixel), with selectable bit order. Completed words go into a show-ahead FIFO with a valid/ready output. Adds frame-reset alignment, overflow detection and a per-frame word counter for the downstream pixel/register logic.

Parameters:
WORD_BITS, 24, bits per output word; legal range 2..32.
FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2.
MSB_FIRST, 1, 1 = first received bit lands in word_data[WORD_BITS-1]; 0 = first bit lands in word_data[0].

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
bit_valid  input  1  one-cycle strobe: bit_value is a decoded bit
bit_value  input  1  decoded bit value
frame_reset  input  1  one-cycle strobe: WS2812B reset/latch gap detected
word_ready  input  1  downstream accepts the head word
word_valid  output  1  FIFO not empty
word_data  output  WORD_BITS  FIFO head word
bit_count  output  $clog2(WORD_BITS)  bits held in the partial word
fifo_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky: a completed word was dropped
overflow_clr  input  1  one-cycle strobe that clears overflow
frame_words  output  16  words accepted into the FIFO since the last frame_reset; saturates at 16'hFFFF

Behaviour:
- Reset (rst_n low, asynchronous): bit_count=0, shift register=0, FIFO empty, word_valid=0, word_data=0, fifo_level=0, overflow=0, frame_words=0. Partial word and FIFO contents are lost.
- Accumulation: each bit_valid cycle shifts bit_value in.
  - MSB_FIRST=1: shift left, insert at bit 0.
  - MSB_FIRST=0: shift right, insert at bit WORD_BITS-1.
  - bit_count increments by 1.
- Word completion: a bit_valid with bit_count==WORD_BITS-1 forms the full word from the shift register plus the incoming bit. That word is pushed in the same cycle, and bit_count returns to 0.
- Latency: last bit at cycle N gives word_valid=1 with the correct word_data at cycle N+1 (FIFO previously empty).
- FIFO is show-ahead: word_data always shows the head word; it holds the last-popped value when the FIFO is empty.
- Handshake: a pop occurs when word_valid and word_ready are both 1. word_data and word_valid must stay stable while word_valid=1 and word_ready=0.
- Push when full:
  - With a pop in the same cycle: the push succeeds and fifo_level is unchanged.
  - Without a pop: the word is dropped, overflow is set, and frame_words does not increment. The shift register and bit_count still reset.
- Push and pop in the same cycle when not full: both happen and fifo_level is unchanged.
- Push into an empty FIFO with word_ready=1: no bypass. The word appears next cycle.
- frame_reset:
  - Next cycle: bit_count=0, shift register=0, frame_words=0.
  - The FIFO is not flushed and overflow is unaffected.
  - If it coincides with bit_valid, frame_reset wins: the bit is discarded and no push occurs, even if that bit would have completed a word.
- frame_words increments on each successful push, with no wrap past 16'hFFFF.
- overflow_clr and an overflow-set event in the same cycle: set wins, overflow stays 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_level distinguishes full (FIFO_DEPTH) from empty (0).
- All outputs are registered or derived directly from registered state. There are no combinational paths from inputs to outputs.

Test Plan:
- Defaults, 24 bits of 0xA5C3F0 sent MSB-first, word_ready=1 -> word_valid rises 1 cycle after the last bit, word_data=24'hA5C3F0, frame_words=1, bit_count=0.
- MSB_FIRST=0, WORD_BITS=8, bits 1,0,0,0,0,0,0,0 -> word_data=8'h01. Same bits with MSB_FIRST=1 -> 8'h80.
- word_ready=0, 5 full words 1..5 with FIFO_DEPTH=4 -> fifo_level=4, overflow=1, frame_words=4. Popping then yields 1,2,3,4 in order; pulsing overflow_clr afterwards gives overflow=0.
- FIFO full, last bit of word 6 arrives in the same cycle as a pop -> no overflow, fifo_level stays 4, later pops give 2,3,4,6.
- 10 bits sent, then frame_reset coincident with the 11th bit_valid -> bit_count=0, no word. The next 24 bits form an exact word; the FIFO keeps words queued before the frame_reset.
- rst_n asserted mid-word with FIFO holding 2 words, no clock edge -> all outputs reach their reset values immediately. After release, a fresh 24-bit word assembles correctly.
